// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- next-PC generator and PC register for the fetch stage.
//
// Selects the next fetch address from NUM_REDIR prioritised redirect sources
// (index 0 highest) or the sequential pc + INC. It holds the PC under stall or
// fetch backpressure, and a BOOT/RUN/HALT controller gates fetch_valid_o.
// A redirect that arrives while the PC is frozen is kept in a one-entry pending
// slot. It is applied on the first cycle the PC is allowed to move again.
//
// Parameters
//   XLEN          PC width in bits
//   RESET_VECTOR  PC value loaded on reset
//   NUM_REDIR     number of redirect sources (index 0 = highest priority)
//   INC           sequential PC increment
//
// Ports
//   clk_i             core clock, rising edge
//   rst_ni            asynchronous active-low reset
//   redir_valid_i     per-source redirect request
//   redir_target_i    packed targets, source i at [i*XLEN +: XLEN]
//   stall_i           freezes all PC updates while high
//   halt_req_i        halt request, honoured on a completed handshake in RUN
//   resume_i          leave HALT when high
//   fetch_ready_i     fetch consumer accepts pc_o this cycle
//   fetch_valid_o     pc_o is valid for fetch (high only in RUN)
//   pc_o              current PC (register output)
//   pc_plus_inc_o     pc_o + INC, modulo 2^XLEN
//   redirect_taken_o  pulse: pc_o was loaded from a redirect on the last edge
//   state_o           BOOT=0, RUN=1, HALT=2
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned       NUM_REDIR    = 3,
    parameter int unsigned       INC          = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REDIR-1:0]      redir_valid_i,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
    input  logic                      stall_i,
    input  logic                      halt_req_i,
    input  logic                      resume_i,
    input  logic                      fetch_ready_i,
    output logic                      fetch_valid_o,
    output logic [XLEN-1:0]           pc_o,
    output logic [XLEN-1:0]           pc_plus_inc_o,
    output logic                      redirect_taken_o,
    output logic [1:0]                state_o
);

    localparam int unsigned IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // ---------------------------------------------------------------- state
    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               redir_taken_q, redir_taken_d;
    logic               pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [XLEN-1:0]    pend_tgt_q, pend_tgt_d;

    // ------------------------------------------------------- handshake terms
    logic               fetch_valid;
    logic               upd;        // PC may change at the next edge
    logic               handshake;  // consumer takes pc_q at the next edge

    assign fetch_valid = (state_q == ST_RUN);

    // With fetch_valid high and fetch_ready low, the PC must not move.
    // This keeps the offered address stable until the consumer takes it.
    assign upd       = !stall_i && (!fetch_valid || fetch_ready_i);
    assign handshake = fetch_valid && fetch_ready_i && !stall_i;

    // ------------------------------------------- current-cycle priority pick
    logic               cur_any;
    logic [IDX_W-1:0]   cur_idx;
    logic [XLEN-1:0]    cur_tgt;

    // NOTE: every combinational output gets a default before the loop or case
    // statement, so no path leaves it unassigned. That prevents an inferred
    // latch.
    always_comb begin
        cur_any = 1'b0;
        cur_idx = '0;
        cur_tgt = '0;
        // Scan from the lowest priority up, so the last hit is the winner.
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid_i[i]) begin
                cur_any = 1'b1;
                cur_idx = IDX_W'(i);
                cur_tgt = redir_target_i[i*XLEN +: XLEN];
            end
        end
    end

    // --------------------------------------- current vs. pending arbitration
    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [XLEN-1:0]    win_tgt;

    // On an equal index, the fresh target wins over the stored one.
    // The newer request from the same source is the more up-to-date intent.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_tgt = '0;
        if (cur_any && (!pend_valid_q || (cur_idx <= pend_idx_q))) begin
            win_any = 1'b1;
            win_idx = cur_idx;
            win_tgt = cur_tgt;
        end else if (pend_valid_q) begin
            win_any = 1'b1;
            win_idx = pend_idx_q;
            win_tgt = pend_tgt_q;
        end
    end

    // ------------------------------------------------------ FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (handshake && halt_req_i) state_d = ST_HALT;
            ST_HALT: if (resume_i)                state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ------------------------------------------------ PC / pending next state
    always_comb begin
        pc_d          = pc_q;
        redir_taken_d = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_idx_d    = pend_idx_q;
        pend_tgt_d    = pend_tgt_q;

        if (upd && win_any) begin
            // A redirect always beats the sequential increment.
            pc_d          = win_tgt;
            redir_taken_d = 1'b1;
            pend_valid_d  = 1'b0;
        end else if (handshake) begin
            pc_d = pc_plus_inc_o;
        end else if (!upd && cur_any) begin
            // Frozen: keep only the best request seen so far.
            // Arbitration already rejected any lower-priority newcomer.
            pend_valid_d = 1'b1;
            pend_idx_d   = win_idx;
            pend_tgt_d   = win_tgt;
        end
    end

    // -------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample their inputs from the same pre-edge values.
    // NOTE: the pending target is reset together with its valid bit.
    // That way no stale address survives a mid-operation reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            redir_taken_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_idx_q    <= '0;
            pend_tgt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_taken_q <= redir_taken_d;
            pend_valid_q  <= pend_valid_d;
            pend_idx_q    <= pend_idx_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign fetch_valid_o    = fetch_valid;
    assign pc_o             = pc_q;
    assign pc_plus_inc_o    = pc_q + XLEN'(INC);
    assign redirect_taken_o = redir_taken_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- scoreboard bench for pc_gen.
//
// The driver applies one stimulus per cycle on the falling edge. It advances a
// behavioural model of the fetch PC rules and queues the expected outputs for
// the coming rising edge. A separate monitor pops and compares after each
// rising edge. Directed scenarios come first, then randomized traffic with
// occasional resets.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 3;
    localparam logic [31:0] RV   = 32'h0000_1000;

    typedef struct packed {
        logic              rst;
        logic [NR-1:0]     valid;
        logic [NR-1:0][31:0] tgt;
        logic              stall;
        logic              halt;
        logic              resume;
        logic              ready;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        rt;
        logic [1:0]  st;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [NR-1:0]        redir_valid_i = '0;
    logic [NR*XLEN-1:0]   redir_target_i = '0;
    logic                 stall_i = 1'b0;
    logic                 halt_req_i = 1'b0;
    logic                 resume_i = 1'b0;
    logic                 fetch_ready_i = 1'b0;
    logic                 fetch_valid_o;
    logic [XLEN-1:0]      pc_o;
    logic [XLEN-1:0]      pc_plus_inc_o;
    logic                 redirect_taken_o;
    logic [1:0]           state_o;

    pc_gen #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .NUM_REDIR(NR), .INC(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .redir_valid_i(redir_valid_i), .redir_target_i(redir_target_i),
        .stall_i(stall_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
        .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o),
        .pc_o(pc_o), .pc_plus_inc_o(pc_plus_inc_o),
        .redirect_taken_o(redirect_taken_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    // Reference model: mode 0=BOOT 1=RUN 2=HALT, pending redirect as a record.
    logic [31:0] m_pc = RV;
    int          m_mode = 0;
    bit          m_rt = 0;
    bit          m_pend_v = 0;
    int          m_pend_idx = 0;
    logic [31:0] m_pend_tgt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    function automatic stim_t idle(input bit ready);
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        s.ready = ready;
        return s;
    endfunction

    // One clock of stimulus plus the model's view of the following edge.
    task automatic step(input stim_t s);
        bit          fv, upd, hs, have;
        int          w_idx;
        logic [31:0] w_tgt;
        exp_t        e;
        @(negedge clk_i);
        rst_ni         = s.rst;
        redir_valid_i  = s.valid;
        redir_target_i = s.tgt;
        stall_i        = s.stall;
        halt_req_i     = s.halt;
        resume_i       = s.resume;
        fetch_ready_i  = s.ready;
        if (!s.rst) begin
            m_pc = RV; m_mode = 0; m_rt = 0; m_pend_v = 0;
            // Reset acts without a clock edge.
            #1;
            check("async_pc", pc_o, RV);
            check("async_state", 32'(state_o), 0);
            check("async_fv", 32'(fetch_valid_o), 0);
            check("async_rt", 32'(redirect_taken_o), 0);
        end else begin
            fv  = (m_mode == 1);
            upd = !s.stall && (!fv || s.ready);
            hs  = fv && s.ready && !s.stall;
            // Candidates: requests seen now, then the stored one.
            // The stored one wins only with a strictly better index.
            have = 0; w_idx = 0; w_tgt = '0;
            for (int i = 0; i < NR; i++)
                if (s.valid[i] && !have) begin have = 1; w_idx = i; w_tgt = s.tgt[i]; end
            if (m_pend_v && (!have || m_pend_idx < w_idx)) begin
                have = 1; w_idx = m_pend_idx; w_tgt = m_pend_tgt;
            end
            m_rt = 0;
            if (upd && have) begin
                m_pc = w_tgt; m_rt = 1; m_pend_v = 0;
            end else if (hs) begin
                m_pc = m_pc + 32'd4;
            end else if (!upd && (s.valid != 0)) begin
                m_pend_v = 1; m_pend_idx = w_idx; m_pend_tgt = w_tgt;
            end
            if (m_mode == 0)                 m_mode = 1;
            else if (m_mode == 1 && hs && s.halt) m_mode = 2;
            else if (m_mode == 2 && s.resume)     m_mode = 1;
        end
        e.pc = m_pc;
        e.fv = (m_mode == 1);
        e.rt = m_rt;
        e.st = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    // Direct check just after the edge the previous step() targeted.
    task automatic after_edge;
        @(posedge clk_i);
        #2;
    endtask

    // Monitor: compares every registered output after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc_o, e.pc);
                check("pc_plus_inc", pc_plus_inc_o, e.pc + 32'd4);
                check("fetch_valid", 32'(fetch_valid_o), 32'(e.fv));
                check("redirect_taken", 32'(redirect_taken_o), 32'(e.rt));
                check("state", 32'(state_o), 32'(e.st));
            end
        end
    end

    initial begin
        stim_t s;

        // Reset, then boot and sequential fetch.
        s = idle(1); s.rst = 0;
        repeat (3) step(s);
        step(idle(1));
        check("boot_state_before_edge", 32'(state_o), 0);
        step(idle(1));
        step(idle(1));
        after_edge();
        check("seq_pc", pc_o, 32'h0000_1008);

        // Backpressure: pc and fetch_valid hold.
        repeat (3) step(idle(0));
        after_edge();
        check("bp_pc", pc_o, 32'h0000_1008);
        check("bp_fv", 32'(fetch_valid_o), 1);

        // Priority: sources 1 and 2 together, source 1 wins.
        s = idle(1); s.valid = 3'b110; s.tgt[1] = 32'h2000; s.tgt[2] = 32'h3000;
        step(s);
        after_edge();
        check("prio_pc", pc_o, 32'h0000_2000);
        check("prio_rt", 32'(redirect_taken_o), 1);
        step(idle(1));

        // Wrap at 2^XLEN.
        s = idle(1); s.valid = 3'b001; s.tgt[0] = 32'hFFFF_FFFC;
        step(s);
        step(idle(1));
        after_edge();
        check("wrap_pc", pc_o, 32'h0000_0000);

        // Pending redirects while stalled; the best request survives.
        s = idle(1); s.stall = 1; s.valid = 3'b100; s.tgt[2] = 32'h3000; step(s);
        s = idle(1); s.stall = 1; s.valid = 3'b001; s.tgt[0] = 32'h4000; step(s);
        s = idle(1); s.stall = 1; s.valid = 3'b010; s.tgt[1] = 32'h5000; step(s);
        step(idle(1));
        after_edge();
        check("pend_pc", pc_o, 32'h0000_4000);
        check("pend_rt", 32'(redirect_taken_o), 1);
        step(idle(1));
        after_edge();
        check("pend_next_pc", pc_o, 32'h0000_4004);

        // Halt and resume, with a redirect taken while halted.
        s = idle(1); s.rst = 0; step(s);
        step(idle(1));
        step(idle(1));
        s = idle(1); s.halt = 1; step(s);
        after_edge();
        check("halt_pc", pc_o, 32'h0000_1008);
        check("halt_state", 32'(state_o), 2);
        s = idle(1); s.valid = 3'b010; s.tgt[1] = 32'h6000; step(s);
        after_edge();
        check("halt_redir_pc", pc_o, 32'h0000_6000);
        check("halt_redir_fv", 32'(fetch_valid_o), 0);
        s = idle(1); s.resume = 1; step(s);
        after_edge();
        check("resume_pc", pc_o, 32'h0000_6000);
        check("resume_state", 32'(state_o), 1);
        step(idle(1));

        // Async reset with a pending redirect: the pending entry is lost.
        s = idle(1); s.stall = 1; s.valid = 3'b100; s.tgt[2] = 32'h7000; step(s);
        s = idle(1); s.stall = 1; s.rst = 0; step(s);
        step(s);
        step(idle(1));
        after_edge();
        check("post_reset_pc", pc_o, RV);
        check("post_reset_rt", 32'(redirect_taken_o), 0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            s = idle($urandom_range(0, 9) < 7);
            s.stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NR; i++) begin
                s.valid[i] = ($urandom_range(0, 7) == 0);
                s.tgt[i]   = $urandom & 32'hFFFF_FFFC;
            end
            s.halt   = ($urandom_range(0, 15) == 0);
            s.resume = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) s.rst = 1'b0;
            step(s);
        end

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-PC generator and PC register for the fetch stage of the RISC-V core.
- Replaces the flat combinational PC select. Supports N prioritised redirect sources, a stall input, and a valid/ready fetch handshake.
- Captures redirects that arrive while the PC is frozen and applies them later.
- Supports halt/resume for debug.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- NUM_REDIR, 3, number of redirect sources. Index 0 has the highest priority.
- INC, 4, sequential PC increment.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- redir_valid  input  NUM_REDIR  per-source redirect request.
- redir_target  input  NUM_REDIR*XLEN  packed targets; source i occupies bits [i*XLEN +: XLEN].
- stall  input  1  freezes all PC updates while high.
- halt_req  input  1  request to halt fetch; sampled in RUN.
- resume  input  1  request to leave HALT; sampled in HALT.
- fetch_ready  input  1  fetch consumer accepts pc this cycle.
- fetch_valid  output  1  pc is valid for fetch.
- pc  output  XLEN  current PC (register output).
- pc_plus_inc  output  XLEN  combinational pc+INC, modulo 2^XLEN.
- redirect_taken  output  1  one-cycle pulse: pc was loaded from a redirect on the previous edge.
- state  output  2  BOOT=0, RUN=1, HALT=2.

Behaviour:
- Reset (rst low, asynchronous):
  - pc=RESET_VECTOR, fetch_valid=0, redirect_taken=0, state=BOOT.
  - Pending redirect cleared.
  - Reset asserted mid-operation discards the pending redirect and any halt.
- States:
  - BOOT: fetch_valid=0. On the first edge after rst releases, go to RUN unconditionally. pc is unchanged.
  - RUN: fetch_valid=1. halt_req high at an edge where a handshake completes (fetch_valid & fetch_ready & !stall) moves to HALT. A halt_req held while no handshake completes stays in RUN.
  - HALT: fetch_valid=0. resume high at an edge moves to RUN.
- Update enable: upd = !stall & (!fetch_valid | fetch_ready).
  - pc and fetch_valid stay stable while fetch_valid & !fetch_ready.
- Redirect selection:
  - Candidate set = current redir_valid plus the pending entry.
  - Winner = lowest source index.
  - On an index tie, the current redir_target wins over the pending target.
- If upd and a winner exists:
  - pc <= winner target; pending cleared; redirect_taken=1 next cycle.
  - A redirect overrides the sequential increment.
- If upd, no winner, and a handshake completes: pc <= pc+INC, wrapping at 2^XLEN.
- If upd, no winner, and no handshake (BOOT/HALT): pc holds.
- If !upd and any redir_valid:
  - The winner among current and pending is stored as pending (index and target).
  - pc holds.
- Pending depth is one entry. A lower-priority later redirect never overwrites a higher-priority pending one.
- Redirects are accepted in BOOT and HALT and applied subject to upd. In HALT the pc then holds the target until resume.
- A redirect and halt_req in the same handshake cycle: pc loads the target and state goes to HALT.
- redirect_taken is 0 in every cycle not immediately following a redirect load.
- Latency: a redirect with upd=1 appears on pc on the next edge. A stalled redirect appears on the edge after upd first goes high.

Test Plan:
- Reset/boot: RESET_VECTOR=32'h0000_1000; release rst, fetch_ready=1 -> cycle0 state=BOOT, fetch_valid=0; then pc=0x1000, 0x1004, 0x1008 on successive handshakes.
- Backpressure and wrap: fetch_ready=0 for 3 cycles -> pc held at 0x1008, fetch_valid=1. Separately, pc=0xFFFF_FFFC with a handshake -> pc=0x0000_0000.
- Priority: redir_valid=3'b110 (targets 0x2000 for source 1, 0x3000 for source 2) with upd=1 -> pc=0x2000 next cycle, redirect_taken pulses once.
- Pending during stall:
  - stall=1, redirect source 2 to 0x3000, then source 0 to 0x4000, then source 1 to 0x5000.
  - Release stall -> pc=0x4000, redirect_taken=1, no pending left.
  - With no further redirects, pc=0x4004 after the next handshake.
- Halt/resume: halt_req on a handshake at pc=0x1004 -> pc=0x1008, state=HALT, fetch_valid=0. A redirect to 0x6000 while in HALT -> pc=0x6000, fetch_valid stays 0. resume -> RUN, first fetched pc=0x6000.
- Async reset mid-stall with pending redirect -> pc=RESET_VECTOR immediately; after release no redirect is applied and redirect_taken=0.
